clkgen_ctrl: RTL and testbench
==============================

Name: clkgen_ctrl

Overview:
- Synthesizable programmable clock-pattern generator and controller, clocked by the system clock.
- Produces a periodic waveform on gen_out with a programmable high time, low time and start phase, all counted in clk cycles.
- Configuration arrives over a valid/ready handshake. It is shadowed and applied only at period boundaries, so the output never glitches mid-period.
- Sequences start, graceful stop and reconfiguration of the generated clock for downstream test and stimulus logic.

Parameters:
- CNT_W, 16, width of the ton/toff/phase cycle counts.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_ton  in  CNT_W  high-time cycles; must be >0.
- cfg_toff  in  CNT_W  low-time cycles; must be >0.
- cfg_phase  in  CNT_W  cycles from start to first high; 0 is allowed.
- start  in  1  begin generation; level sampled each cycle.
- stop  in  1  request stop; level sampled each cycle.
- gen_out  out  1  generated waveform.
- running  out  1  state != IDLE.
- period_done  out  1  one-cycle pulse in the last LOW cycle of each period.
- cfg_err  out  1  one-cycle pulse when an accepted config is rejected.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE; gen_out, running, period_done and cfg_err are 0; cfg_ready=1.
  - Active and pending configs are cleared; cfg_loaded=0; stop_pend=0.
  - Reset mid-operation takes effect at that edge; gen_out is low from the next cycle.
- States:
  - IDLE: gen_out=0.
  - PHASE: gen_out=0; counts phase cycles.
  - HIGH: gen_out=1; counts ton cycles.
  - LOW: gen_out=0; counts toff cycles.
- gen_out is decoded from the state register only, so it is glitch-free with zero combinational input paths.
- Config handshake:
  - A transfer happens when cfg_valid and cfg_ready are both 1.
  - If ton==0 or toff==0, the config is discarded and cfg_err pulses the next cycle.
  - In IDLE, a valid config writes the active registers directly and sets cfg_loaded=1.
  - While running, a valid config writes the pending register. cfg_ready=0 until the pending config is applied at the next period boundary, i.e. the last LOW cycle.
  - While running, a second config offered before that boundary waits, because cfg_ready=0.
- Start:
  - Acts only in IDLE with cfg_loaded=1. Otherwise it is ignored, and is ignored while running.
  - At the sampling edge, the block goes to PHASE if phase>0, else to HIGH.
  - gen_out rises `phase` cycles after the start edge.
- Transitions:
  - PHASE → HIGH after phase cycles.
  - HIGH → LOW after ton cycles.
  - LOW → HIGH after toff cycles, using the pending config if one is present.
- Stop:
  - Stop while in HIGH or LOW sets stop_pend. At the end of the current LOW the block goes to IDLE, completing the period; period_done still pulses.
  - Stop while in PHASE goes to IDLE at the next edge.
  - Simultaneous start and stop in IDLE: stop wins and the block stays IDLE.
- Pending config when stop completes: it is still applied to the active registers on entry to IDLE.
- Counter:
  - A single down-counter, loaded with N-1 on state entry. The state transitions when the counter reaches 0.
  - Each state therefore lasts exactly N cycles; ton=1 gives a one-cycle high.
  - No wrap: the maximum N is 2^CNT_W-1.
- cfg_err and period_done are registered pulses and never last more than one cycle.

Decomposition:
- Shared package clkgen_pkg:
  - state enum (IDLE, PHASE, HIGH, LOW);
  - default CNT_W;
  - packed struct clkgen_cfg_t {ton, toff, phase}.
- One natural sub-module, clkgen_cnt: a loadable down-counter with a zero flag, parameterized by CNT_W.
- The FSM, shadow registers and handshake stay in clkgen_ctrl.

Test Plan:
- Basic waveform: cfg ton=5, toff=5, phase=2; start at edge E0.
  - gen_out rises at E0+2, high for 5 cycles, low for 5, period 10.
  - period_done pulses on the 10th cycle of each period.
- Zero phase and minimal times: cfg ton=1, toff=1, phase=0; start.
  - gen_out rises on the start edge and toggles every cycle.
  - running=1 throughout.
- Reconfigure while running:
  - ton=3, toff=3 running; offer ton=2, toff=6 mid-HIGH.
  - cfg_ready drops; the current period completes as 3/3; the next period is 2/6; cfg_ready returns to 1.
- Error config: ton=0, toff=4 offered in IDLE.
  - Handshake completes, cfg_err pulses for 1 cycle, cfg_loaded stays 0, and a following start is ignored.
- Graceful stop: ton=4, toff=4; assert stop in the 2nd HIGH cycle.
  - The period finishes with 4 low cycles; period_done pulses; IDLE next; running=0.
  - With stop in PHASE instead (phase=8), IDLE follows 1 cycle later and gen_out never rises.
- Reset mid-HIGH: assert rst.
  - gen_out=0, running=0, cfg_ready=1 the next cycle.
  - A start then does nothing until the block is reconfigured.

Source files
------------

// File: rtl/clkgen_pkg.sv
// ---------------------------------------------------------------------------
// clkgen_pkg
// Shared definitions for the programmable clock-pattern generator:
//   - CLKGEN_CNT_W : default width of the ton/toff/phase cycle counts
//   - clkgen_state_e : controller state encoding
//   - clkgen_cfg_t : one complete waveform configuration at the default width
// ---------------------------------------------------------------------------
package clkgen_pkg;

  localparam int CLKGEN_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } clkgen_state_e;

  typedef struct packed {
    logic [CLKGEN_CNT_W-1:0] ton;
    logic [CLKGEN_CNT_W-1:0] toff;
    logic [CLKGEN_CNT_W-1:0] phase;
  } clkgen_cfg_t;

  // Build a default-width configuration from its three fields.
  function automatic clkgen_cfg_t clkgen_mk_cfg(
    input logic [CLKGEN_CNT_W-1:0] ton,
    input logic [CLKGEN_CNT_W-1:0] toff,
    input logic [CLKGEN_CNT_W-1:0] phase
  );
    clkgen_cfg_t c;
    c.ton   = ton;
    c.toff  = toff;
    c.phase = phase;
    return c;
  endfunction

endpackage

// File: rtl/clkgen_if.sv
// ---------------------------------------------------------------------------
// clkgen_if
// Configuration valid/ready channel for clkgen_ctrl.
//   cfg_valid : configuration offered (master -> slave)
//   cfg_ready : configuration can be accepted (slave -> master)
//   cfg_ton   : high-time cycles, must be nonzero
//   cfg_toff  : low-time cycles, must be nonzero
//   cfg_phase : cycles from start to first high, zero allowed
// Modports: master (configuration source), slave (clkgen_ctrl).
// ---------------------------------------------------------------------------
interface clkgen_if
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CLKGEN_CNT_W
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_ton;
  logic [CNT_W-1:0] cfg_toff;
  logic [CNT_W-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_ton,
    output cfg_toff,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ton,
    input  cfg_toff,
    input  cfg_phase,
    output cfg_ready
  );

endinterface

// File: rtl/clkgen_cnt.sv
// ---------------------------------------------------------------------------
// clkgen_cnt
// Loadable down-counter with zero flags, used to time each controller state.
//   clk         : system clock
//   rst         : synchronous active-high reset, clears the count
//   load_i      : load load_val_i this cycle (has priority over dec_i)
//   load_val_i  : value to load (state length minus one)
//   dec_i       : decrement this cycle; the count holds at zero, never wraps
//   zero_o      : current count is zero
//   next_zero_o : count after this edge will be zero (lookahead for
//                 registered pulses that must line up with the zero cycle)
// ---------------------------------------------------------------------------
module clkgen_cnt
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CLKGEN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             next_zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins over a decrement, and the count parks at zero
  // so an unexpected extra decrement can never wrap to the maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o      = (cnt_q == '0);
  assign next_zero_o = (cnt_d == '0);

endmodule

// File: rtl/clkgen_ctrl.sv
// ---------------------------------------------------------------------------
// clkgen_ctrl
// Programmable clock-pattern generator. Produces a periodic waveform with
// programmable high time, low time and start phase (all in clk cycles).
// Configuration is shadowed and only takes effect at period boundaries.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   cfg         : configuration channel (clkgen_if slave)
//   start       : begin generation (only in IDLE with a loaded config)
//   stop        : request stop (graceful from HIGH/LOW, immediate in PHASE)
//   gen_out     : generated waveform, straight from a flop
//   running     : controller is not IDLE
//   period_done : one-cycle pulse in the last LOW cycle of each period
//   cfg_err     : one-cycle pulse after a config with ton or toff of zero
// ---------------------------------------------------------------------------
module clkgen_ctrl
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CLKGEN_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  clkgen_if.slave  cfg,
  input  logic     start,
  input  logic     stop,
  output logic     gen_out,
  output logic     running,
  output logic     period_done,
  output logic     cfg_err
);

  typedef struct packed {
    logic [CNT_W-1:0] ton;
    logic [CNT_W-1:0] toff;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  clkgen_state_e    state_q, state_d;
  cfg_t             act_q, act_d;
  cfg_t             pend_q, pend_d;
  cfg_t             cfg_in;
  logic             pend_vld_q, pend_vld_d;
  logic             loaded_q, loaded_d;
  logic             stop_pend_q, stop_pend_d;
  logic             gen_out_q, running_q, period_done_q, cfg_err_q, cfg_ready_q;

  logic             xfer, cfg_bad, start_go, stop_now;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_next_zero;
  logic [CNT_W-1:0] cnt_val;

  // State timer: each state loads its length minus one on entry and the
  // controller moves on when the count reaches zero.
  clkgen_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .load_i      (cnt_load),
    .load_val_i  (cnt_val),
    .dec_i       (cnt_dec),
    .zero_o      (cnt_zero),
    .next_zero_o (cnt_next_zero)
  );

  // Next-state, counter control and shadow-register update.
  // A config accepted while the controller stays in IDLE goes straight into
  // the active set; otherwise it waits in the pending set, which is copied
  // into the active set at the end of the current LOW phase (or when a stop
  // returns us to IDLE). cfg_ready mirrors "pending slot empty", so an
  // accepted config can never overwrite one that is still waiting.
  // Stop seen on the very last LOW edge counts as well as a stored request.
  always_comb begin
    cfg_in.ton   = cfg.cfg_ton;
    cfg_in.toff  = cfg.cfg_toff;
    cfg_in.phase = cfg.cfg_phase;

    xfer     = cfg.cfg_valid && cfg_ready_q;
    cfg_bad  = (cfg_in.ton == '0) || (cfg_in.toff == '0);
    start_go = start && !stop && loaded_q;
    stop_now = stop || stop_pend_q;

    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = (state_q != IDLE);
    act_d       = act_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    loaded_d    = loaded_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      IDLE: begin
        if (start_go) begin
          cnt_load = 1'b1;
          if (act_q.phase != '0) begin
            state_d = PHASE;
            cnt_val = act_q.phase - CNT_W'(1);
          end else begin
            state_d = HIGH;
            cnt_val = act_q.ton - CNT_W'(1);
          end
        end
      end
      PHASE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d  = HIGH;
          cnt_load = 1'b1;
          cnt_val  = act_q.ton - CNT_W'(1);
        end
      end
      HIGH: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (cnt_zero) begin
          state_d  = LOW;
          cnt_load = 1'b1;
          cnt_val  = act_q.toff - CNT_W'(1);
        end
      end
      LOW: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (cnt_zero) begin
          if (stop_now) begin
            state_d = IDLE;
          end else begin
            state_d  = HIGH;
            cnt_load = 1'b1;
            if (pend_vld_q) begin
              cnt_val    = pend_q.ton - CNT_W'(1);
              act_d      = pend_q;
              pend_vld_d = 1'b0;
            end else begin
              cnt_val = act_q.ton - CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == IDLE) && (state_q != IDLE)) begin
      stop_pend_d = 1'b0;
      if (pend_vld_q) begin
        act_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end

    if (xfer && !cfg_bad) begin
      if (state_d == IDLE) begin
        act_d    = cfg_in;
        loaded_d = 1'b1;
      end else begin
        pend_d     = cfg_in;
        pend_vld_d = 1'b1;
      end
    end
  end

  // Controller registers. All outputs are flops computed from the next
  // state, so gen_out has no combinational path from any input.
  // period_done uses the counter lookahead so the pulse sits exactly in the
  // last LOW cycle rather than one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      act_q         <= '0;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      loaded_q      <= 1'b0;
      stop_pend_q   <= 1'b0;
      gen_out_q     <= 1'b0;
      running_q     <= 1'b0;
      period_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      loaded_q      <= loaded_d;
      stop_pend_q   <= stop_pend_d;
      gen_out_q     <= (state_d == HIGH);
      running_q     <= (state_d != IDLE);
      period_done_q <= (state_d == LOW) && cnt_next_zero;
      cfg_err_q     <= xfer && cfg_bad;
      cfg_ready_q   <= !pend_vld_d;
    end
  end

  assign gen_out       = gen_out_q;
  assign running       = running_q;
  assign period_done   = period_done_q;
  assign cfg_err       = cfg_err_q;
  assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_clkgen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clkgen_ctrl
// Directed self-checking bench for clkgen_ctrl. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point, so each sample
// index k below is "just after the k-th edge following the start edge".
// ---------------------------------------------------------------------------
module tb_clkgen_ctrl;
  import clkgen_pkg::*;

  logic clk;
  logic rst;
  logic start;
  logic stop;
  logic genOut;
  logic running;
  logic periodDone;
  logic cfgErr;

  int nCompared;
  int nMismatched;

  clkgen_if #(.CNT_W(16)) cfgIf ();

  clkgen_ctrl #(
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfgIf),
    .start       (start),
    .stop        (stop),
    .gen_out     (genOut),
    .running     (running),
    .period_done (periodDone),
    .cfg_err     (cfgErr)
  );

  // Free-running 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive all inputs for one cycle, then advance past the next rising edge.
  task automatic applyStimulus(input logic startV, input logic stopV,
                               input logic validV, input clkgen_cfg_t c);
    start           = startV;
    stop            = stopV;
    cfgIf.cfg_valid = validV;
    cfgIf.cfg_ton   = c.ton;
    cfgIf.cfg_toff  = c.toff;
    cfgIf.cfg_phase = c.phase;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, clkgen_mk_cfg(16'd0, 16'd0, 16'd0));
  endtask

  // Request a stop and give the generator a bounded time to reach IDLE.
  task automatic stopAndWait(input string tag);
    applyStimulus(1'b0, 1'b1, 1'b0, clkgen_mk_cfg(16'd0, 16'd0, 16'd0));
    for (int i = 0; i < 60; i++) begin
      if (!running) break;
      idleCycle();
    end
    checkOutput(tag, running, 0);
  endtask

  initial begin
    clkgen_cfg_t none;
    logic [15:0] expGen, expPd, expRdy, expRun;

    nCompared   = 0;
    nMismatched = 0;
    none        = clkgen_mk_cfg(16'd0, 16'd0, 16'd0);
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    cfgIf.cfg_valid = 1'b0;
    cfgIf.cfg_ton   = '0;
    cfgIf.cfg_toff  = '0;
    cfgIf.cfg_phase = '0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, none);
    rst = 1'b0;
    checkOutput("rst_gen", genOut, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_pd", periodDone, 0);
    checkOutput("rst_err", cfgErr, 0);
    checkOutput("rst_ready", cfgIf.cfg_ready, 1);

    // Basic waveform 5/5 phase 2: rise at k=2, period 10, done at k=11,21
    $display("[TB] basic waveform 5/5/2");
    applyStimulus(1'b0, 1'b0, 1'b1, clkgen_mk_cfg(16'd5, 16'd5, 16'd2));
    checkOutput("t1_err", cfgErr, 0);
    checkOutput("t1_running_before", running, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    for (int k = 0; k < 26; k++) begin
      checkOutput($sformatf("t1_gen[%0d]", k), genOut,
                  ((k >= 2) && (((k - 2) % 10) < 5)) ? 1 : 0);
      checkOutput($sformatf("t1_pd[%0d]", k), periodDone,
                  ((k >= 2) && (((k - 2) % 10) == 9)) ? 1 : 0);
      idleCycle();
    end
    stopAndWait("t1_idle");

    // Zero phase, 1/1: high on the start edge, toggles every cycle
    $display("[TB] minimal waveform 1/1/0");
    applyStimulus(1'b0, 1'b0, 1'b1, clkgen_mk_cfg(16'd1, 16'd1, 16'd0));
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t2_gen[%0d]", k), genOut, (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("t2_pd[%0d]", k), periodDone, (k % 2 == 1) ? 1 : 0);
      checkOutput($sformatf("t2_running[%0d]", k), running, 1);
      idleCycle();
    end
    stopAndWait("t2_idle");

    // Reconfigure 3/3 -> 2/6 offered in the 2nd HIGH cycle
    $display("[TB] reconfigure while running");
    applyStimulus(1'b0, 1'b0, 1'b1, clkgen_mk_cfg(16'd3, 16'd3, 16'd0));
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    expGen = 16'b1100_0000_1100_0111;
    expPd  = 16'b0010_0000_0010_0000;
    expRdy = 16'b1111_1111_1100_0011;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("t3_gen[%0d]", k), genOut, expGen[k]);
      checkOutput($sformatf("t3_pd[%0d]", k), periodDone, expPd[k]);
      checkOutput($sformatf("t3_ready[%0d]", k), cfgIf.cfg_ready, expRdy[k]);
      applyStimulus(1'b0, 1'b0, (k == 1), clkgen_mk_cfg(16'd2, 16'd6, 16'd0));
    end
    stopAndWait("t3_idle");

    // Error config after reset: rejected, start ignored
    $display("[TB] rejected config");
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, clkgen_mk_cfg(16'd0, 16'd4, 16'd0));
    checkOutput("t4_err_pulse", cfgErr, 1);
    checkOutput("t4_ready", cfgIf.cfg_ready, 1);
    idleCycle();
    checkOutput("t4_err_clear", cfgErr, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    checkOutput("t4_start_ignored", running, 0);
    idleCycle();
    checkOutput("t4_gen", genOut, 0);

    // Simultaneous start and stop in IDLE: stays IDLE
    applyStimulus(1'b0, 1'b0, 1'b1, clkgen_mk_cfg(16'd4, 16'd4, 16'd0));
    applyStimulus(1'b1, 1'b1, 1'b0, none);
    checkOutput("t5_startstop", running, 0);

    // Graceful stop in 2nd HIGH cycle: period completes, done at k=7
    $display("[TB] graceful stop");
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    expGen = 16'h000F;
    expPd  = 16'h0080;
    expRun = 16'h00FF;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("t5_gen[%0d]", k), genOut, expGen[k]);
      checkOutput($sformatf("t5_pd[%0d]", k), periodDone, expPd[k]);
      checkOutput($sformatf("t5_running[%0d]", k), running, expRun[k]);
      applyStimulus(1'b0, (k == 1), 1'b0, none);
    end

    // Stop during PHASE: IDLE one cycle later, never rises
    $display("[TB] stop in phase");
    applyStimulus(1'b0, 1'b0, 1'b1, clkgen_mk_cfg(16'd4, 16'd4, 16'd8));
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    checkOutput("t6_phase_running", running, 1);
    checkOutput("t6_phase_gen", genOut, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, none);
    checkOutput("t6_stopped", running, 0);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("t6_gen[%0d]", k), genOut, 0);
      idleCycle();
    end

    // Reset mid-HIGH, then start without a config does nothing
    $display("[TB] reset mid-high");
    applyStimulus(1'b0, 1'b0, 1'b1, clkgen_mk_cfg(16'd6, 16'd6, 16'd0));
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    idleCycle();
    checkOutput("t7_high", genOut, 1);
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
    checkOutput("t7_rst_gen", genOut, 0);
    checkOutput("t7_rst_running", running, 0);
    checkOutput("t7_rst_ready", cfgIf.cfg_ready, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    checkOutput("t7_start_ignored", running, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, clkgen_mk_cfg(16'd2, 16'd2, 16'd0));
    applyStimulus(1'b1, 1'b0, 1'b0, none);
    checkOutput("t7_restart_gen", genOut, 1);
    checkOutput("t7_restart_running", running, 1);
    stopAndWait("t7_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
